arm_multicycle_controller: RTL and testbench
============================================

Name: arm_multicycle_controller

Overview:
- Control unit that sequences the shared-datapath (multicycle) ARM core: one memory port for instructions and data, one ALU for PC increment and execution.
- Decodes the latched instruction and runs the main FSM, ALU decoder, condition check and NZCV flag register.
- Drives every enable and mux select of the datapath; sits beside the datapath inside top.

Parameters:
- RESET_STATE, FETCH, state entered while reset is asserted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  live ALU result flags {N,Z,C,V}.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUResult register.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  1  0=RD1 register, 1=PC.
- ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4.
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- ImmSrc  out  2  Instr[27:26] passthrough.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- State  out  4  current FSM state, for debug.

Behaviour:
- Decode fields: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
- Reset (reset=0 at clk edge): state=FETCH, Flags=0000, cond_q=0.
  - While reset=0, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=00 with Funct[5]=0 -> EXECR.
    - Op=00 with Funct[5]=1 -> EXECI.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (executes as a NOP, no writes).
  - MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR, EXECI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- Per-state outputs (signals not listed are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALU decoder selects ALUControl.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALU decoder selects ALUControl.
  - MEMADR: ALUSrcA=0, ALUSrcB=01; ADD when Funct[3]=1, SUB when Funct[3]=0.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=cond_q.
  - MEMWRITE: AdrSrc=1, MemWrite=cond_q.
  - ALUWB: ResultSrc=00, RegWrite=cond_q & (Funct[4:1]!=1010).
    - PCWrite=cond_q when Rd=15.
    - CMP (Funct[4:1]=1010) never writes a register.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_q.
- ALU decoder, Funct[4:1] to ALUControl:
  - 0100 ADD -> 00.
  - 0010 SUB -> 01.
  - 0000 AND -> 10.
  - 1100 ORR -> 11.
  - 1010 CMP -> SUB (01).
  - Any other value -> ADD (00), no register write, no flag write.
- Condition check:
  - cond_q <= condex(Cond, Flags), registered at the end of DECODE.
  - All gated writes use cond_q, never the live flags.
  - condex covers all 15 ARM conditions: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - Cond=1111 evaluates to 0.
- Flag update, at the rising edge that ends EXECR or EXECI:
  - Only when Funct[0]=1 (S bit), or when the op is CMP.
  - Only when cond_q=1.
  - N,Z always update; C,V update for ADD/SUB/CMP only; AND/ORR leave C,V unchanged.
- Latency in clk cycles:
  - Data processing: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Op=11: 2.
- Reset mid-instruction: abandons the sequence with no partial writes; the next instruction fetch starts at the first cycle after reset returns to 1.

Decomposition:
- Package arm_ctrl_pkg:
  - state encoding (4-bit enum, FETCH=0);
  - ALUControl codes;
  - Op codes (DP=00, MEM=01, BR=10);
  - cond codes;
  - ResultSrc and ALUSrcB encodings.
- One sub-module: arm_cond_unit.
  - Contains the Flags register, the condex function, cond_q and the flag-write logic.
  - The FSM and ALU decoder stay in the top controller.

Test Plan:
- Reset held low 2 cycles, then released:
  - State=FETCH and all write enables 0 during reset.
  - First cycle after release: IRWrite=1, PCWrite=1.
- Instr=E0812002 (ADD R2,R1,R2):
  - State sequence FETCH, DECODE, EXECR, ALUWB, FETCH.
  - ALUControl=00 in EXECR; RegWrite=1 only in ALUWB.
- Instr=E2510005 (SUBS R0,R1,#5) with ALUFlags=0110 in EXECI:
  - Flags=0110 afterwards.
  - Next Instr=0A000002 (BEQ): BRANCH state with PCWrite=1.
  - Same sequence with ALUFlags=0000 in EXECI: PCWrite=0 in BRANCH.
- Instr=E5912000 (LDR): FETCH, DECODE, MEMADR, MEMREAD, MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- Instr=15812000 (STRNE) with Flags.Z=1: MEMWRITE reached with MemWrite=0; Flags unchanged.
- reset=0 during MEMREAD:
  - Next state FETCH, RegWrite never asserted.
  - Flags=0000 afterwards.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU codes,
// opcode classes, condition codes and datapath mux selects.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing opcodes as seen in Funct[4:1]
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition evaluation; cond_q freezes the verdict at
// the end of DECODE so later gated writes never see flags changing underneath.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_cond,
    input  logic       flag_we,
    input  logic       flag_we_cv,
    output logic       cond_q
);

    logic [3:0] flags_q;

    function automatic logic condex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, res;
        {n, z, cy, v} = f;
        case (c)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = cy;
            COND_CC: res = ~cy;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = cy & ~z;
            COND_LS: res = ~cy | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Condition latch and NZCV register; C,V only move for arithmetic ops
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            if (latch_cond) begin
                cond_q <= condex(cond, flags_q);
            end
            if (flag_we && cond_q) begin
                flags_q[3:2] <= alu_flags[3:2];
                if (flag_we_cv) begin
                    flags_q[1:0] <= alu_flags[1:0];
                end
            end
        end
    end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Main FSM and ALU decoder of the multicycle ARM core; drives all datapath
// enables and mux selects, with conditional gating from arm_cond_unit.
module arm_multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter state_e RESET_STATE = ST_FETCH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic       unused_instr;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign cond  = Instr[31:28];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    state_e state_q;
    state_e state_d;

    logic [1:0] dp_ctrl_s;
    logic       dp_known_s;
    logic       dp_cmp_s;
    logic       dp_arith_s;
    logic       cond_q;

    logic pc_write_s;
    logic mem_write_s;
    logic ir_write_s;
    logic reg_write_s;

    // ALU decoder: unsupported opcodes fall back to ADD with no side effects
    always_comb begin
        dp_ctrl_s  = ALU_ADD;
        dp_known_s = 1'b1;
        case (funct[4:1])
            DP_ADD:  dp_ctrl_s = ALU_ADD;
            DP_SUB:  dp_ctrl_s = ALU_SUB;
            DP_AND:  dp_ctrl_s = ALU_AND;
            DP_ORR:  dp_ctrl_s = ALU_ORR;
            DP_CMP:  dp_ctrl_s = ALU_SUB;
            default: dp_known_s = 1'b0;
        endcase
    end

    assign dp_cmp_s   = (funct[4:1] == DP_CMP);
    assign dp_arith_s = (funct[4:1] == DP_ADD) | (funct[4:1] == DP_SUB) | dp_cmp_s;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_DP:   state_d = funct[5] ? ST_EXECI : ST_EXECR;
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_BR:   state_d = ST_BRANCH;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD: state_d = ST_MEMWB;
            ST_EXECR:   state_d = ST_ALUWB;
            ST_EXECI:   state_d = ST_ALUWB;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        pc_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RD2;
        ALUControl  = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            ST_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            ST_EXECR: begin
                ALUControl = dp_ctrl_s;
            end
            ST_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_ctrl_s;
            end
            ST_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
            end
            ST_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            ST_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = cond_q;
            end
            ST_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = cond_q;
            end
            ST_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_s = cond_q & dp_known_s & ~dp_cmp_s;
                pc_write_s  = cond_q & (rd == 4'd15);
            end
            ST_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                pc_write_s = cond_q;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Write enables are squashed for the whole time reset is held
    assign PCWrite  = reset & pc_write_s;
    assign MemWrite = reset & mem_write_s;
    assign IRWrite  = reset & ir_write_s;
    assign RegWrite = reset & reg_write_s;
    assign ImmSrc   = op;
    assign RegSrc   = {op == OP_MEM, op == OP_BR};
    assign State    = state_q;

    arm_cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .latch_cond (state_q == ST_DECODE),
        .flag_we    (((state_q == ST_EXECR) | (state_q == ST_EXECI)) & dp_known_s
                     & (funct[0] | dp_cmp_s)),
        .flag_we_cv (dp_arith_s),
        .cond_q     (cond_q)
    );

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench: per instruction, a reference model pushes the expected
// per-cycle state and control word, which are popped and compared each cycle.
module tb_arm_multicycle_controller;
    import arm_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  State;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] m_flags;

    arm_multicycle_controller u_dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] model_alu(input logic [3:0] f41);
        if (f41 == 4'b0010 || f41 == 4'b1010) return 2'b01;
        if (f41 == 4'b0000) return 2'b10;
        if (f41 == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [15:0] exp_ctl(input state_e st, input logic [31:0] ins,
                                            input logic cq, input logic rst_n);
        logic pcw, adr, mw, irw, rw, sa, known;
        logic [1:0] rs, sb, ac, op;
        logic [3:0] f41;
        op  = ins[27:26];
        f41 = ins[24:21];
        known = (f41 == 4'b0100) || (f41 == 4'b0010) || (f41 == 4'b0000) ||
                (f41 == 4'b1100) || (f41 == 4'b1010);
        {pcw, adr, mw, irw, rw, sa} = 6'b000000;
        rs = 2'b00; sb = 2'b00; ac = 2'b00;
        case (st)
            ST_FETCH:    begin pcw = 1'b1; irw = 1'b1; sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            ST_DECODE:   begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            ST_MEMADR:   begin sb = 2'b01; ac = ins[23] ? 2'b00 : 2'b01; end
            ST_MEMREAD:  adr = 1'b1;
            ST_MEMWB:    begin rs = 2'b01; rw = cq; end
            ST_MEMWRITE: begin adr = 1'b1; mw = cq; end
            ST_EXECR:    ac = model_alu(f41);
            ST_EXECI:    begin sb = 2'b01; ac = model_alu(f41); end
            ST_ALUWB:    begin rw = cq && known && f41 != 4'b1010; pcw = cq && ins[15:12] == 4'hF; end
            ST_BRANCH:   begin sb = 2'b01; rs = 2'b10; pcw = cq; end
            default:     pcw = 1'b0;
        endcase
        if (!rst_n) {pcw, mw, irw, rw} = 4'b0000;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, op, op == 2'b01, op == 2'b10};
    endfunction

    function automatic logic [15:0] dut_ctl();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc};
    endfunction

    // Entered at a negedge in the FETCH cycle; abort_after>0 pulls reset in that cycle
    task automatic issue(input string name, input logic [31:0] ins, input logic [3:0] af,
                         input int abort_after);
        state_e seq[$];
        logic cq, known, cmp;
        exp_t e;
        logic [3:0] f41;
        Instr = ins;
        ALUFlags = af;
        f41 = ins[24:21];
        cq = model_cond(ins[31:28], m_flags);
        seq = '{ST_FETCH, ST_DECODE};
        case (ins[27:26])
            2'b00: begin seq.push_back(ins[25] ? ST_EXECI : ST_EXECR); seq.push_back(ST_ALUWB); end
            2'b01: if (ins[20]) begin
                       seq.push_back(ST_MEMADR); seq.push_back(ST_MEMREAD); seq.push_back(ST_MEMWB);
                   end else begin
                       seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWRITE);
                   end
            2'b10: seq.push_back(ST_BRANCH);
            default: ;
        endcase
        foreach (seq[i]) begin
            e.st  = seq[i];
            e.ctl = exp_ctl(seq[i], ins, (i >= 2) ? cq : 1'b0, 1'b1);
            sb_q.push_back(e);
        end
        known = (f41 == 4'b0100) || (f41 == 4'b0010) || (f41 == 4'b0000) ||
                (f41 == 4'b1100) || (f41 == 4'b1010);
        cmp = (f41 == 4'b1010);
        if (abort_after == 0 && ins[27:26] == 2'b00 && cq && known && (ins[20] || cmp)) begin
            m_flags[3:2] = af[3:2];
            if (f41 == 4'b0100 || f41 == 4'b0010 || cmp) m_flags[1:0] = af[1:0];
        end
        for (int i = 0; sb_q.size() > 0; i++) begin
            #1;
            e = sb_q.pop_front();
            check_eq($sformatf("%s state c%0d", name, i), State, e.st);
            check_eq($sformatf("%s ctl c%0d", name, i), dut_ctl(), e.ctl);
            if (abort_after != 0 && i == abort_after - 1) begin
                reset = 1'b0;
                sb_q.delete();
                m_flags = 4'b0000;
                @(negedge clk);
                #1;
                check_eq($sformatf("%s rst state", name), State, ST_FETCH);
                check_eq($sformatf("%s rst ctl", name), dut_ctl(), exp_ctl(ST_FETCH, ins, 1'b0, 1'b0));
                reset = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        Instr = 32'h0000_0000;
        ALUFlags = 4'b0000;
        m_flags = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("reset state", State, ST_FETCH);
            check_eq("reset ctl", dut_ctl(), exp_ctl(ST_FETCH, 32'h0000_0000, 1'b0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;

        issue("ADD",     32'hE081_2002, 4'b0000, 0);
        issue("SUBS_z",  32'hE251_0005, 4'b0110, 0);
        check_eq("flags after SUBS", u_dut.u_cond.flags_q, m_flags);
        issue("BEQ_t",   32'h0A00_0002, 4'b0000, 0);
        issue("SUBS_nz", 32'hE251_0005, 4'b0000, 0);
        check_eq("flags after SUBS2", u_dut.u_cond.flags_q, m_flags);
        issue("BEQ_nt",  32'h0A00_0002, 4'b0000, 0);
        issue("LDR",     32'hE591_2000, 4'b0000, 0);
        issue("SUBS_z2", 32'hE251_0005, 4'b0110, 0);
        issue("STRNE",   32'h1581_2000, 4'b1111, 0);
        check_eq("flags after STRNE", u_dut.u_cond.flags_q, 4'b0110);
        issue("ORRS",    32'hE191_0002, 4'b1001, 0);
        check_eq("flags after ORRS", u_dut.u_cond.flags_q, m_flags);
        issue("CMP",     32'hE151_0002, 4'b0011, 0);
        check_eq("flags after CMP", u_dut.u_cond.flags_q, m_flags);
        issue("ADD_pc",  32'hE081_F002, 4'b0000, 0);
        issue("NOP11",   32'hEC00_0000, 4'b0000, 0);
        issue("LDR_rst", 32'hE591_2000, 4'b0000, 4);
        check_eq("flags after reset", u_dut.u_cond.flags_q, 4'b0000);
        issue("ADD_post", 32'hE081_2002, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
